// File: rtl/clusterv_sram_march_bist.sv
// March C- built-in self test engine for the byte-enable SRAM port.
// Runs M0..M5 over the full address range and reports pass/fail, error count and first-failure capture.
//
// state     | meaning
// S_IDLE    | waiting for start, no SRAM access
// S_WR_ONLY | M0 write of the all-zeros word, one address per cycle
// S_RD      | read strobe to the current address
// S_WAIT    | read latency padding (READ_LATENCY-1 cycles)
// S_WR      | compare returned data and write the element's value (M1..M4)
// S_CHK     | compare returned data only (M5)
// S_DONE    | test finished, status held until the next start
module clusterv_sram_march_bist #(
   parameter int ADDR_WIDTH   = 10,
   parameter int DATA_WIDTH   = 32,
   parameter int READ_LATENCY = 1
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    start,
   input  logic                    abort,
   output logic                    busy,
   output logic                    done,
   output logic                    pass,
   output logic [15:0]             error_count,
   output logic [ADDR_WIDTH-1:0]   fail_addr,
   output logic [DATA_WIDTH-1:0]   fail_expected,
   output logic [DATA_WIDTH-1:0]   fail_actual,
   output logic [ADDR_WIDTH-1:0]   i_addr,
   output logic                    i_read_en,
   output logic                    i_write_en,
   output logic [DATA_WIDTH/8-1:0] i_byte_en,
   output logic [DATA_WIDTH-1:0]   i_write_data,
   input  logic [DATA_WIDTH-1:0]   i_read_data
);

   localparam int BE_W = DATA_WIDTH / 8;
   localparam logic [ADDR_WIDTH-1:0] ADDR_MAX  = '1;
   localparam logic [1:0]            WAIT_INIT = (READ_LATENCY > 1) ? 2'(READ_LATENCY - 2) : 2'd0;

   typedef enum logic [2:0] {
      S_IDLE, S_WR_ONLY, S_RD, S_WAIT, S_WR, S_CHK, S_DONE
   } state_t;

   state_t                  state_q, state_d;
   logic [2:0]              elem_q, elem_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [1:0]              wait_q, wait_d;
   logic                    busy_q, busy_d;
   logic                    done_q, done_d;
   logic                    pass_q, pass_d;
   logic [15:0]             err_q, err_d;
   logic [ADDR_WIDTH-1:0]   fail_addr_q, fail_addr_d;
   logic [DATA_WIDTH-1:0]   fail_exp_q, fail_exp_d;
   logic [DATA_WIDTH-1:0]   fail_act_q, fail_act_d;
   logic [ADDR_WIDTH-1:0]   i_addr_q, i_addr_d;
   logic                    i_read_en_q, i_read_en_d;
   logic                    i_write_en_q, i_write_en_d;
   logic [BE_W-1:0]         i_byte_en_q, i_byte_en_d;
   logic [DATA_WIDTH-1:0]   i_write_data_q, i_write_data_d;

   logic                    elem_up;
   logic                    last_addr;
   logic [DATA_WIDTH-1:0]   exp_data;

   always_comb begin
      state_d        = state_q;
      elem_d         = elem_q;
      addr_d         = addr_q;
      wait_d         = wait_q;
      busy_d         = busy_q;
      done_d         = done_q;
      pass_d         = pass_q;
      err_d          = err_q;
      fail_addr_d    = fail_addr_q;
      fail_exp_d     = fail_exp_q;
      fail_act_d     = fail_act_q;
      i_addr_d       = '0;
      i_read_en_d    = 1'b0;
      i_write_en_d   = 1'b0;
      i_byte_en_d    = '0;
      i_write_data_d = '0;

      // M1..M2 walk upward, M3..M5 walk downward
      elem_up   = (elem_q < 3'd3);
      last_addr = elem_up ? (addr_q == ADDR_MAX) : (addr_q == '0);
      exp_data  = ((elem_q == 3'd2) || (elem_q == 3'd4)) ? {DATA_WIDTH{1'b1}} : '0;

      case (state_q)
         S_IDLE, S_DONE: begin
            if (start && !abort) begin
               state_d     = S_WR_ONLY;
               elem_d      = 3'd0;
               addr_d      = '0;
               busy_d      = 1'b1;
               done_d      = 1'b0;
               pass_d      = 1'b0;
               err_d       = '0;
               fail_addr_d = '0;
               fail_exp_d  = '0;
               fail_act_d  = '0;
            end
         end
         S_WR_ONLY: begin
            if (addr_q == ADDR_MAX) begin
               elem_d  = 3'd1;
               addr_d  = '0;
               state_d = S_RD;
            end else begin
               addr_d = addr_q + 1'b1;
            end
         end
         S_RD: begin
            if (READ_LATENCY > 1) begin
               state_d = S_WAIT;
               wait_d  = WAIT_INIT;
            end else begin
               state_d = (elem_q == 3'd5) ? S_CHK : S_WR;
            end
         end
         S_WAIT: begin
            if (wait_q == 2'd0) state_d = (elem_q == 3'd5) ? S_CHK : S_WR;
            else                wait_d  = wait_q - 2'd1;
         end
         S_WR, S_CHK: begin
            if (i_read_data != exp_data) begin
               if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
               if (err_q == 16'd0) begin
                  fail_addr_d = addr_q;
                  fail_exp_d  = exp_data;
                  fail_act_d  = i_read_data;
               end
            end
            if (last_addr) begin
               if (elem_q == 3'd5) begin
                  state_d = S_DONE;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  pass_d  = (err_d == 16'd0);
               end else begin
                  elem_d  = elem_q + 3'd1;
                  addr_d  = (elem_q >= 3'd2) ? ADDR_MAX : '0;
                  state_d = S_RD;
               end
            end else begin
               addr_d  = elem_up ? addr_q + 1'b1 : addr_q - 1'b1;
               state_d = S_RD;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (abort && busy_q) begin
         state_d = S_IDLE;
         busy_d  = 1'b0;
         done_d  = 1'b0;
         pass_d  = 1'b0;
      end

      // SRAM strobes are registered so they line up with the state they belong to
      i_write_en_d = (state_d == S_WR_ONLY) || (state_d == S_WR);
      i_read_en_d  = (state_d == S_RD);
      if (i_write_en_d || i_read_en_d) i_addr_d = addr_d;
      if (i_write_en_d) begin
         i_byte_en_d    = '1;
         i_write_data_d = elem_d[0] ? {DATA_WIDTH{1'b1}} : '0;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q        <= S_IDLE;
         elem_q         <= 3'd0;
         addr_q         <= '0;
         wait_q         <= 2'd0;
         busy_q         <= 1'b0;
         done_q         <= 1'b0;
         pass_q         <= 1'b0;
         err_q          <= '0;
         fail_addr_q    <= '0;
         fail_exp_q     <= '0;
         fail_act_q     <= '0;
         i_addr_q       <= '0;
         i_read_en_q    <= 1'b0;
         i_write_en_q   <= 1'b0;
         i_byte_en_q    <= '0;
         i_write_data_q <= '0;
      end else begin
         state_q        <= state_d;
         elem_q         <= elem_d;
         addr_q         <= addr_d;
         wait_q         <= wait_d;
         busy_q         <= busy_d;
         done_q         <= done_d;
         pass_q         <= pass_d;
         err_q          <= err_d;
         fail_addr_q    <= fail_addr_d;
         fail_exp_q     <= fail_exp_d;
         fail_act_q     <= fail_act_d;
         i_addr_q       <= i_addr_d;
         i_read_en_q    <= i_read_en_d;
         i_write_en_q   <= i_write_en_d;
         i_byte_en_q    <= i_byte_en_d;
         i_write_data_q <= i_write_data_d;
      end
   end

   assign busy          = busy_q;
   assign done          = done_q;
   assign pass          = pass_q;
   assign error_count   = err_q;
   assign fail_addr     = fail_addr_q;
   assign fail_expected = fail_exp_q;
   assign fail_actual   = fail_act_q;
   assign i_addr        = i_addr_q;
   assign i_read_en     = i_read_en_q;
   assign i_write_en    = i_write_en_q;
   assign i_byte_en     = i_byte_en_q;
   assign i_write_data  = i_write_data_q;

endmodule

// File: tb/tb_clusterv_sram_march_bist.sv
// Bench for the March C- engine: a 1024-word latency-1 SRAM (optionally with a stuck-at bit)
// and a 16-word latency-3 SRAM, each with an access-sequence monitor.
module tb_clusterv_sram_march_bist;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic rst_n, rst_b_n;
   logic fault_en;

   logic        start_a, abort_a, busy_a, done_a, pass_a;
   logic [15:0] err_a;
   logic [9:0]  faddr_a, addr_a;
   logic [31:0] fexp_a, fact_a, wd_a, rd_a;
   logic        re_a, we_a;
   logic [3:0]  be_a;

   logic        start_b, abort_b, busy_b, done_b, pass_b;
   logic [15:0] err_b;
   logic [3:0]  faddr_b, addr_b;
   logic [31:0] fexp_b, fact_b, wd_b, rd_b;
   logic        re_b, we_b;
   logic [3:0]  be_b;

   clusterv_sram_march_bist #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .READ_LATENCY(1)) u_dut_a (
      .clock(clock), .reset(rst_n), .start(start_a), .abort(abort_a),
      .busy(busy_a), .done(done_a), .pass(pass_a), .error_count(err_a),
      .fail_addr(faddr_a), .fail_expected(fexp_a), .fail_actual(fact_a),
      .i_addr(addr_a), .i_read_en(re_a), .i_write_en(we_a), .i_byte_en(be_a),
      .i_write_data(wd_a), .i_read_data(rd_a));

   clusterv_sram_march_bist #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .READ_LATENCY(3)) u_dut_b (
      .clock(clock), .reset(rst_b_n), .start(start_b), .abort(abort_b),
      .busy(busy_b), .done(done_b), .pass(pass_b), .error_count(err_b),
      .fail_addr(faddr_b), .fail_expected(fexp_b), .fail_actual(fact_b),
      .i_addr(addr_b), .i_read_en(re_b), .i_write_en(we_b), .i_byte_en(be_b),
      .i_write_data(wd_b), .i_read_data(rd_b));

   // SRAM models; word 0x2A7 bit 5 is stuck at 1 when fault_en is set
   logic [31:0] mem_a [1024] = '{default: 32'hDEADBEEF};
   logic [31:0] mem_b [16]   = '{default: 32'h5A5A5A5A};
   logic [31:0] pipe_b0 = '0, pipe_b1 = '0, pipe_b2 = '0;
   logic [31:0] stuck_mask;
   assign stuck_mask = (fault_en && addr_a == 10'h2A7) ? 32'h0000_0020 : 32'h0;
   initial rd_a = '0;

   always @(posedge clock) begin
      if (we_a) mem_a[addr_a] <= wd_a | stuck_mask;
      if (re_a) rd_a <= mem_a[addr_a] | stuck_mask;
   end

   always @(posedge clock) begin
      if (we_b) mem_b[addr_b] <= wd_b;
      if (re_b) pipe_b0 <= mem_b[addr_b];
      pipe_b1 <= pipe_b0;
      pipe_b2 <= pipe_b1;
   end
   assign rd_b = pipe_b2;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   int idx_a = 0, last_a = 0, perr_a = 0, strobes_a = 0;
   int idx_b = 0, last_b = 0, perr_b = 0, strobes_b = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // k-th SRAM access of a full March C- run: kind, address, write value, spacing from previous access
   function automatic void exp_op(input int k, input int aw, input int lat,
                                  output bit is_wr, output int addr, output bit ones, output int gap);
      int n, j, e, r, pos;
      n = 1 << aw;
      is_wr = 1'b0; addr = 0; ones = 1'b0; gap = 1;
      if (k < n) begin
         is_wr = 1'b1;
         addr  = k;
      end else if (k < 9 * n) begin
         j   = k - n;
         e   = j / (2 * n);
         r   = j % (2 * n);
         pos = r / 2;
         addr = (e < 2) ? pos : n - 1 - pos;
         if (r % 2 == 1) begin
            is_wr = 1'b1;
            ones  = (e % 2 == 0);
            gap   = lat;
         end
      end else begin
         j    = k - 9 * n;
         addr = n - 1 - j;
         gap  = (j == 0) ? 1 : lat + 1;
      end
   endfunction

   task automatic mon(input logic re, input logic we, input logic [3:0] be, input int addr,
                      input logic [31:0] wd, input int aw, input int lat,
                      inout int idx, inout int last, inout int perr, inout int strobes);
      bit ew, eo;
      int ea, eg;
      if (re && we) perr++;
      if (we && be !== 4'hF) perr++;
      if (!we && be !== 4'h0) perr++;
      if (re || we) begin
         strobes++;
         if (idx >= 10 * (1 << aw)) begin
            perr++;
         end else begin
            exp_op(idx, aw, lat, ew, ea, eo, eg);
            if (we !== ew || addr != ea) perr++;
            if (we && wd !== (eo ? 32'hFFFF_FFFF : 32'h0)) perr++;
            if (idx > 0 && (cyc - last) != eg) perr++;
         end
         idx++;
         last = cyc;
      end
   endtask

   task automatic tick();
      @(negedge clock);
      cyc++;
      mon(re_a, we_a, be_a, int'(addr_a), wd_a, 10, 1, idx_a, last_a, perr_a, strobes_a);
      mon(re_b, we_b, be_b, int'(addr_b), wd_b, 4, 3, idx_b, last_b, perr_b, strobes_b);
   endtask

   task automatic pulse_a();
      start_a = 1'b1;
      tick();
      start_a = 1'b0;
   endtask

   task automatic pulse_b();
      start_b = 1'b1;
      tick();
      start_b = 1'b0;
   endtask

   task automatic wait_done_a();
      int guard = 0;
      while (busy_a && guard < 20000) begin
         guard++;
         tick();
      end
   endtask

   task automatic wait_done_b();
      int guard = 0;
      while (busy_b && guard < 2000) begin
         guard++;
         tick();
      end
   endtask

   initial begin
      int t0, s;
      rst_n = 1'b0; rst_b_n = 1'b0; fault_en = 1'b0;
      start_a = 1'b0; abort_a = 1'b0; start_b = 1'b0; abort_b = 1'b0;
      repeat (3) tick();
      check("rst_busy", busy_a, 1'b0);
      check("rst_done", done_a, 1'b0);
      check("rst_pass", pass_a, 1'b0);
      check("rst_err", err_a, 16'h0);
      check("rst_faddr", faddr_a, 10'h0);
      check("rst_strobes", {re_a, we_a, be_a}, 6'h0);
      check("rst_addr_wd", {addr_a, wd_a}, 42'h0);
      rst_n = 1'b1; rst_b_n = 1'b1;
      tick();

      // clean run, latency 1
      idx_a = 0; perr_a = 0;
      pulse_a();
      check("t1_busy", busy_a, 1'b1);
      check("t1_first_wr", {we_a, re_a, addr_a}, {2'b10, 10'h0});
      t0 = cyc;
      wait_done_a();
      check("t1_cycles", cyc - t0, 11264);
      check("t1_done", done_a, 1'b1);
      check("t1_pass", pass_a, 1'b1);
      check("t1_err", err_a, 16'h0);
      check("t1_ops", idx_a, 10240);
      check("t1_proto", perr_a, 0);

      // stuck-at-1 on bit 5 of word 0x2A7
      fault_en = 1'b1;
      idx_a = 0; perr_a = 0;
      pulse_a();
      t0 = cyc;
      wait_done_a();
      check("t2_cycles", cyc - t0, 11264);
      check("t2_done", done_a, 1'b1);
      check("t2_pass", pass_a, 1'b0);
      check("t2_err", err_a, 16'd3);
      check("t2_faddr", faddr_a, 10'h2A7);
      check("t2_fexp", fexp_a, 32'h0000_0000);
      check("t2_fact", fact_a, 32'h0000_0020);
      check("t2_proto", perr_a, 0);
      fault_en = 1'b0;

      // restart from done clears status; a start while busy is ignored
      idx_a = 0; perr_a = 0;
      pulse_a();
      check("t5_done_clr", done_a, 1'b0);
      check("t5_busy", busy_a, 1'b1);
      check("t5_pass_clr", pass_a, 1'b0);
      check("t5_err_clr", err_a, 16'h0);
      check("t5_fail_clr", {faddr_a, fexp_a, fact_a}, 74'h0);
      t0 = cyc;
      repeat (99) tick();
      pulse_a();
      wait_done_a();
      check("t5_cycles", cyc - t0, 11264);
      check("t5_pass", pass_a, 1'b1);
      check("t5_ops", idx_a, 10240);
      check("t5_proto", perr_a, 0);

      // abort at busy cycle 5000
      idx_a = 0; perr_a = 0;
      pulse_a();
      repeat (4999) tick();
      check("t4_busy_pre", busy_a, 1'b1);
      abort_a = 1'b1;
      tick();
      abort_a = 1'b0;
      check("t4_busy", busy_a, 1'b0);
      check("t4_done", done_a, 1'b0);
      check("t4_pass", pass_a, 1'b0);
      check("t4_bus_idle", {re_a, we_a, be_a, addr_a, wd_a}, 48'h0);
      s = strobes_a;
      repeat (20) tick();
      check("t4_no_strobes", strobes_a - s, 0);
      abort_a = 1'b1; start_a = 1'b1;
      tick();
      abort_a = 1'b0; start_a = 1'b0;
      check("t4_abort_wins", busy_a, 1'b0);
      check("t4_proto_pre", perr_a, 0);
      idx_a = 0;
      pulse_a();
      t0 = cyc;
      wait_done_a();
      check("t4_cycles", cyc - t0, 11264);
      check("t4_pass", pass_a, 1'b1);
      check("t4_proto", perr_a, 0);

      // latency 3, 16 words
      idx_b = 0; perr_b = 0;
      pulse_b();
      t0 = cyc;
      wait_done_b();
      check("t3_cycles", cyc - t0, 336);
      check("t3_done", done_b, 1'b1);
      check("t3_pass", pass_b, 1'b1);
      check("t3_err", err_b, 16'h0);
      check("t3_ops", idx_b, 160);
      check("t3_proto", perr_b, 0);

      // reset in the middle of a run
      idx_b = 0;
      pulse_b();
      repeat (50) tick();
      rst_b_n = 1'b0;
      #1;
      check("rst_mid_busy", {busy_b, done_b, pass_b}, 3'b000);
      check("rst_mid_bus", {re_b, we_b, be_b, addr_b, wd_b}, 42'h0);
      s = strobes_b;
      repeat (5) tick();
      check("rst_mid_no_strobes", strobes_b - s, 0);
      rst_b_n = 1'b1;
      tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
